retire_trace_buffer: RTL and testbench

//  Parametrised instruction-retire trace capture for the RISC-V core. Sits beside the processor
//  and records one entry per retired instruction (pc, inst, rd, wdata, flags) into a circular

---
 rtl/retire_trace_buffer.sv | 169 ++++++++++++++++
 tb/tb_retire_trace_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: circular capture of retired-instruction records
// with pc/memwrite trigger, post-trigger window and stop-when-full mode.
//
// Ports:
//   CLK, RST          clock, async active-low reset
//   ret_*             retire record input (valid, pc, inst, rd, wdata, flags)
//   trig_mode/trig_pc trigger selection and match pc
//   arm, stop         restart capture / force DONE
//   rd_ready, rd_*    head record drain interface
//   count, state      records held, capture state
//   triggered         trigger fired since last arm
//   overflow          record overwritten or dropped since last arm
module retire_trace_buffer #(
    parameter int XLEN      = 64,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ret_valid,
    input  logic [XLEN-1:0]          ret_pc,
    input  logic [31:0]              ret_inst,
    input  logic [4:0]               ret_rd,
    input  logic [XLEN-1:0]          ret_wdata,
    input  logic                     ret_regwrite,
    input  logic                     ret_memwrite,
    input  logic [1:0]               trig_mode,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [31:0]              rd_inst,
    output logic [4:0]               rd_rd,
    output logic [XLEN-1:0]          rd_wdata,
    output logic [1:0]               rd_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state,
    output logic                     triggered,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POST    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          st;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   post_cnt;

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [31:0]     mem_inst  [DEPTH];
    logic [4:0]      mem_rd    [DEPTH];
    logic [XLEN-1:0] mem_wdata [DEPTH];
    logic [1:0]      mem_flags [DEPTH];

    logic capturing;
    logic full;
    logic m_fill;
    logic wr_en;
    logic drop;
    logic fill_done;
    logic trigger;
    logic pop;

    assign state     = st;
    assign capturing = (st == CAPTURE) || (st == POST);
    assign full      = (count == CNT_FULL);
    assign m_fill    = (trig_mode == 2'b11);

    // Stop-when-full mode refuses to overwrite; the record is dropped.
    assign wr_en = capturing && ret_valid && !arm && !(m_fill && full);
    assign drop  = capturing && ret_valid && !arm && m_fill && full;

    assign fill_done = (m_fill && wr_en && count == CNT_LAST) || drop;

    // stop wins over a same-cycle trigger, so it is masked here.
    assign trigger = (st == CAPTURE) && ret_valid && !stop &&
                     (((trig_mode == 2'b01) && (ret_pc == trig_pc)) ||
                      ((trig_mode == 2'b10) && ret_memwrite));

    assign rd_valid = ((st == IDLE) || (st == DONE)) && (count != '0);
    assign pop      = rd_valid && rd_ready && !arm;

    // Fields read as zero whenever no record is offered.
    assign rd_pc    = rd_valid ? mem_pc[rd_ptr]    : '0;
    assign rd_inst  = rd_valid ? mem_inst[rd_ptr]  : '0;
    assign rd_rd    = rd_valid ? mem_rd[rd_ptr]    : '0;
    assign rd_wdata = rd_valid ? mem_wdata[rd_ptr] : '0;
    assign rd_flags = rd_valid ? mem_flags[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_pc[wr_ptr]    <= ret_pc;
            mem_inst[wr_ptr]  <= ret_inst;
            mem_rd[wr_ptr]    <= ret_rd;
            mem_wdata[wr_ptr] <= ret_wdata;
            mem_flags[wr_ptr] <= {ret_regwrite, ret_memwrite};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st        <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else if (arm) begin
            st        <= CAPTURE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (full) begin
                    rd_ptr   <= rd_ptr + PTR_ONE;
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_ONE;
                end
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                count  <= count - CNT_ONE;
            end
            if (drop) overflow <= 1'b1;

            unique case (st)
                CAPTURE: begin
                    if (stop || fill_done) begin
                        st <= DONE;
                    end else if (trigger) begin
                        triggered <= 1'b1;
                        post_cnt  <= POST_INIT;
                        st        <= (POST_TRIG == 0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (stop || fill_done) begin
                        st <= DONE;
                    end else if (ret_valid) begin
                        post_cnt <= post_cnt - PTR_ONE;
                        if (post_cnt == PTR_ONE) st <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: table-driven vectors plus
// hand sequences for reset, overwrite, pc trigger and fill modes.
module tb_retire_trace_buffer;

    logic        CLK;
    logic        RST;
    logic        ret_valid;
    logic [63:0] ret_pc;
    logic [31:0] ret_inst;
    logic [4:0]  ret_rd;
    logic [63:0] ret_wdata;
    logic        ret_regwrite;
    logic        ret_memwrite;
    logic [1:0]  trig_mode;
    logic [63:0] trig_pc;
    logic        arm;
    logic        stop;
    logic        rd_ready;

    logic        rd_valid;
    logic [63:0] rd_pc;
    logic [31:0] rd_inst;
    logic [4:0]  rd_rd;
    logic [63:0] rd_wdata;
    logic [1:0]  rd_flags;
    logic [4:0]  count;
    logic [1:0]  state;
    logic        triggered;
    logic        overflow;

    logic        z_valid;
    logic [63:0] z_pc;
    logic [31:0] z_inst;
    logic [4:0]  z_rd;
    logic [63:0] z_wdata;
    logic [1:0]  z_flags;
    logic [4:0]  z_count;
    logic [1:0]  z_state;
    logic        z_trig;
    logic        z_ovf;

    int checks = 0;
    int errors = 0;

    retire_trace_buffer #(.XLEN(64), .DEPTH(16), .POST_TRIG(4)) dut (
        .CLK(CLK), .RST(RST),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
        .ret_rd(ret_rd), .ret_wdata(ret_wdata),
        .ret_regwrite(ret_regwrite), .ret_memwrite(ret_memwrite),
        .trig_mode(trig_mode), .trig_pc(trig_pc),
        .arm(arm), .stop(stop), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst),
        .rd_rd(rd_rd), .rd_wdata(rd_wdata), .rd_flags(rd_flags),
        .count(count), .state(state),
        .triggered(triggered), .overflow(overflow)
    );

    retire_trace_buffer #(.XLEN(64), .DEPTH(16), .POST_TRIG(0)) dut0 (
        .CLK(CLK), .RST(RST),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
        .ret_rd(ret_rd), .ret_wdata(ret_wdata),
        .ret_regwrite(ret_regwrite), .ret_memwrite(ret_memwrite),
        .trig_mode(trig_mode), .trig_pc(trig_pc),
        .arm(arm), .stop(stop), .rd_ready(rd_ready),
        .rd_valid(z_valid), .rd_pc(z_pc), .rd_inst(z_inst),
        .rd_rd(z_rd), .rd_wdata(z_wdata), .rd_flags(z_flags),
        .count(z_count), .state(z_state),
        .triggered(z_trig), .overflow(z_ovf)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        arm;
        logic        stop;
        logic        rv;
        logic        rw;
        logic        mw;
        logic        rdy;
        logic [63:0] pc;
        logic [1:0]  st;
        int          cnt;
        logic        vld;
        logic        trg;
        logic [63:0] hpc;
        logic [1:0]  fl;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic retire(input logic [63:0] pc, input logic mw);
        ret_valid    = 1'b1;
        ret_pc       = pc;
        ret_inst     = pc[31:0] ^ 32'h13;
        ret_rd       = pc[6:2];
        ret_wdata    = ~pc;
        ret_memwrite = mw;
        ret_regwrite = ~mw;
        step();
        ret_valid    = 1'b0;
        ret_memwrite = 1'b0;
        ret_regwrite = 1'b0;
    endtask

    task automatic drain(input int n, input logic [63:0] first);
        for (int k = 0; k < n; k++) begin
            chk("drain_valid", 64'(rd_valid), 64'd1);
            chk("drain_pc", rd_pc, first + 64'(4 * k));
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
        end
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_empty", 64'(rd_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] done_pc;

        RST = 1'b0;
        ret_valid = 0; ret_pc = '0; ret_inst = '0; ret_rd = '0;
        ret_wdata = '0; ret_regwrite = 0; ret_memwrite = 0;
        trig_mode = 2'b00; trig_pc = '0;
        arm = 0; stop = 0; rd_ready = 0;

        tbl[0]  = '{1,0,0,0,0,0, 64'h0,   2'd1, 0, 0, 0, 64'h0,   2'b00};
        tbl[1]  = '{0,0,1,1,0,0, 64'h100, 2'd1, 1, 0, 0, 64'h0,   2'b00};
        tbl[2]  = '{0,0,1,1,0,0, 64'h104, 2'd1, 2, 0, 0, 64'h0,   2'b00};
        tbl[3]  = '{0,0,1,0,1,0, 64'h108, 2'd3, 3, 1, 1, 64'h100, 2'b10};
        tbl[4]  = '{0,0,1,0,1,0, 64'h10C, 2'd3, 3, 1, 1, 64'h100, 2'b10};
        tbl[5]  = '{0,0,0,0,0,1, 64'h0,   2'd3, 2, 1, 1, 64'h104, 2'b10};
        tbl[6]  = '{0,0,0,0,0,1, 64'h0,   2'd3, 1, 1, 1, 64'h108, 2'b01};
        tbl[7]  = '{1,0,0,0,0,0, 64'h0,   2'd1, 0, 0, 0, 64'h0,   2'b00};
        tbl[8]  = '{0,0,1,1,0,0, 64'h200, 2'd1, 1, 0, 0, 64'h0,   2'b00};
        tbl[9]  = '{0,0,1,1,0,0, 64'h204, 2'd1, 2, 0, 0, 64'h0,   2'b00};
        tbl[10] = '{0,0,1,1,0,0, 64'h208, 2'd1, 3, 0, 0, 64'h0,   2'b00};
        tbl[11] = '{0,0,1,0,1,0, 64'h20C, 2'd3, 4, 1, 1, 64'h200, 2'b10};
        tbl[12] = '{0,0,0,0,0,0, 64'h0,   2'd3, 4, 1, 1, 64'h200, 2'b10};
        tbl[13] = '{0,0,0,0,0,0, 64'h0,   2'd3, 4, 1, 1, 64'h200, 2'b10};
        tbl[14] = '{0,0,0,0,0,0, 64'h0,   2'd3, 4, 1, 1, 64'h200, 2'b10};
        tbl[15] = '{0,0,0,0,0,1, 64'h0,   2'd3, 3, 1, 1, 64'h204, 2'b10};
        tbl[16] = '{1,0,0,0,0,1, 64'h0,   2'd1, 0, 0, 0, 64'h0,   2'b00};
        tbl[17] = '{0,1,1,0,1,0, 64'h300, 2'd3, 1, 1, 0, 64'h300, 2'b01};

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_pc", rd_pc, 64'd0);
        chk("rst_trig", 64'(triggered), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        RST = 1'b1;
        step();

        // Asynchronous reset in the middle of a capture
        trig_mode = 2'b00;
        pulse_arm();
        for (int i = 0; i < 5; i++) retire(64'(4 * i), 1'b0);
        chk("t1_state", 64'(state), 64'd1);
        chk("t1_count", 64'(count), 64'd5);
        #2 RST = 1'b0;
        #1;
        chk("t1_rst_state", 64'(state), 64'd0);
        chk("t1_rst_count", 64'(count), 64'd0);
        chk("t1_rst_valid", 64'(rd_valid), 64'd0);
        #3 RST = 1'b1;
        step();

        // Free-run overwrite, then stop
        trig_mode = 2'b00;
        pulse_arm();
        for (int i = 0; i < 20; i++) retire(64'(4 * i), 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t2_state", 64'(state), 64'd3);
        chk("t2_count", 64'(count), 64'd16);
        chk("t2_ovf", 64'(overflow), 64'd1);
        chk("t2_trig", 64'(triggered), 64'd0);
        drain(16, 64'h10);

        // PC trigger with four post-trigger records
        trig_mode = 2'b01;
        trig_pc = 64'h40;
        pulse_arm();
        done_pc = '1;
        for (int i = 0; i < 24; i++) begin
            retire(64'(4 * i), 1'b0);
            if (state == 2'd3 && done_pc == '1) done_pc = 64'(4 * i);
        end
        chk("t3_done_pc", done_pc, 64'h50);
        chk("t3_trig", 64'(triggered), 64'd1);
        chk("t3_count", 64'(count), 64'd16);
        chk("t3_ovf", 64'(overflow), 64'd1);
        drain(16, 64'h14);

        // Stop-when-full
        trig_mode = 2'b11;
        pulse_arm();
        done_pc = '1;
        for (int i = 0; i < 18; i++) begin
            retire(64'(4 * i), 1'b0);
            if (state == 2'd3 && done_pc == '1) done_pc = 64'(4 * i);
        end
        chk("t4_done_pc", done_pc, 64'h3C);
        chk("t4_count", 64'(count), 64'd16);
        chk("t4_ovf", 64'(overflow), 64'd0);
        chk("t4_trig", 64'(triggered), 64'd0);
        drain(16, 64'h0);

        // Memwrite trigger, zero post window, readout and stop cases
        trig_mode = 2'b10;
        for (int i = 0; i < 18; i++) begin
            arm          = tbl[i].arm;
            stop         = tbl[i].stop;
            ret_valid    = tbl[i].rv;
            ret_regwrite = tbl[i].rw;
            ret_memwrite = tbl[i].mw;
            ret_pc       = tbl[i].pc;
            ret_inst     = tbl[i].pc[31:0];
            ret_rd       = tbl[i].pc[6:2];
            ret_wdata    = ~tbl[i].pc;
            rd_ready     = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_state", i), 64'(z_state), 64'(tbl[i].st));
            chk($sformatf("v%0d_count", i), 64'(z_count), 64'(tbl[i].cnt));
            chk($sformatf("v%0d_valid", i), 64'(z_valid), 64'(tbl[i].vld));
            chk($sformatf("v%0d_trig", i), 64'(z_trig), 64'(tbl[i].trg));
            chk($sformatf("v%0d_pc", i), z_pc, tbl[i].hpc);
            chk($sformatf("v%0d_flags", i), 64'(z_flags), 64'(tbl[i].fl));
            chk($sformatf("v%0d_ovf", i), 64'(z_ovf), 64'd0);
        end
        arm = 0; stop = 0; ret_valid = 0; ret_regwrite = 0;
        ret_memwrite = 0; rd_ready = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
